// File: rtl/carry_skip_adder_pipe_if.sv
// Operand/result bundle for carry_skip_adder_pipe.
// master: in_valid, a, b, cin out; out_valid, sum, carry_out in. slave: reverse.
interface carry_skip_adder_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, carry_out
  );
endinterface

// File: rtl/carry_skip_adder_pipe.sv
// Registered WIDTH-bit carry-skip adder: sum = a + b + cin, BLOCK-bit skip blocks.
// Ports: clk, rst (async high), bus (slave: in_valid,a,b,cin -> out_valid,sum,carry_out).
// CSA_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module carry_skip_adder_pipe #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input logic                   clk,
  input logic                   rst,
  carry_skip_adder_pipe_if.slave bus
);

  localparam int NB = (BLOCK > 0) ? WIDTH / BLOCK : 1;

  if (WIDTH < 1 || BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of BLOCK");
  end

  logic             op_v;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_c;

`ifdef CSA_INPUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_v <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_c <= 1'b0;
    end else begin
      op_v <= bus.in_valid;
      op_a <= bus.a;
      op_b <= bus.b;
      op_c <= bus.cin;
    end
  end
`else
  assign op_v = bus.in_valid;
  assign op_a = bus.a;
  assign op_b = bus.b;
  assign op_c = bus.cin;
`endif

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] s;
  logic             cout;

  assign p = op_a ^ op_b;
  assign g = op_a & op_b;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic             ci;
    logic             rc;
    logic             co;
    logic [BLOCK-1:0] bs;

    if (k == 0) begin : g_first
      assign ci = op_c;
    end else begin : g_next
      assign ci = g_blk[k-1].co;
    end

    always_comb begin
      logic c;
      c  = ci;
      bs = '0;
      for (int j = 0; j < BLOCK; j++) begin
        bs[j] = p[k*BLOCK+j] ^ c;
        c     = g[k*BLOCK+j] | (p[k*BLOCK+j] & c);
      end
      rc = c;
    end

    // Skip mux: a fully propagating block passes its carry-in straight through,
    // so the long carry chain only sees one mux per block.
    assign co = (&p[k*BLOCK +: BLOCK]) ? ci : rc;
    assign s[k*BLOCK +: BLOCK] = bs;
  end

  assign cout = g_blk[NB-1].co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.carry_out <= 1'b0;
    end else begin
      bus.out_valid <= op_v;
      if (op_v) begin
        bus.sum       <= s;
        bus.carry_out <= cout;
      end
    end
  end

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Directed/exhaustive/random bench for carry_skip_adder_pipe.
// Runs a WIDTH=4/BLOCK=2 and a WIDTH=16/BLOCK=4 instance side by side.
module tb_carry_skip_adder_pipe;

`ifdef CSA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  carry_skip_adder_pipe_if #(.WIDTH(4))  b4 ();
  carry_skip_adder_pipe_if #(.WIDTH(16)) b16 ();

  carry_skip_adder_pipe #(.WIDTH(4), .BLOCK(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  carry_skip_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  typedef struct packed {
    logic        v;
    logic [16:0] r;
  } exp_t;

  exp_t        q4[$];
  exp_t        q16[$];
  logic [16:0] h4;
  logic [16:0] h16;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [16:0] got,
                     input logic [16:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic restart();
    q4.delete();
    q16.delete();
    h4  = '0;
    h16 = '0;
    for (int i = 0; i < LAT - 1; i++) begin
      q4.push_back('0);
      q16.push_back('0);
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = q4.pop_front();
    if (e.v) h4 = e.r;
    chk({tag, ".v4"}, 17'(b4.out_valid), 17'(e.v));
    chk({tag, ".s4"}, 17'({b4.carry_out, b4.sum}), h4);
    e = q16.pop_front();
    if (e.v) h16 = e.r;
    chk({tag, ".v16"}, 17'(b16.out_valid), 17'(e.v));
    chk({tag, ".s16"}, {b16.carry_out, b16.sum}, h16);
  endtask

  task automatic step4(input string tag, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic ci,
                       input logic [4:0] r);
    b4.in_valid  = v;
    b4.a         = a;
    b4.b         = b;
    b4.cin       = ci;
    b16.in_valid = 1'b0;
    q4.push_back({v, 17'(r)});
    q16.push_back('0);
    tick(tag);
  endtask

  task automatic step16(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic ci);
    b4.in_valid  = 1'b0;
    b16.in_valid = 1'b1;
    b16.a        = a;
    b16.b        = b;
    b16.cin      = ci;
    q4.push_back('0);
    q16.push_back({1'b1, 17'(a) + 17'(b) + 17'(ci)});
    tick(tag);
  endtask

  initial begin
    logic [4:0] r;

    b4.in_valid  = 1'b1;
    b4.a         = 4'b1010;
    b4.b         = 4'b0000;
    b4.cin       = 1'b0;
    b16.in_valid = 1'b0;
    b16.a        = '0;
    b16.b        = '0;
    b16.cin      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.v", 17'(b4.out_valid), 17'd0);
    chk("rst.s", 17'({b4.carry_out, b4.sum}), 17'd0);
    chk("rst.v16", 17'(b16.out_valid), 17'd0);
    rst = 1'b0;
    restart();

    step4("b0", 1, 4'b0000, 4'b0000, 0, 5'b0_0000);
    step4("b1", 1, 4'b1010, 4'b0000, 0, 5'b0_1010);
    step4("b2", 1, 4'b0110, 4'b0110, 1, 5'b0_1101);
    step4("b3", 1, 4'b0110, 4'b1011, 0, 5'b1_0001);
    step4("b4", 1, 4'b1001, 4'b0000, 1, 5'b0_1010);
    step4("b5", 1, 4'b0110, 4'b1111, 1, 5'b1_0110);
    step4("b6", 1, 4'b1111, 4'b0000, 0, 5'b0_1111);

    step4("sk0", 1, 4'b1111, 4'b0000, 1, 5'b1_0000);
    step4("sk1", 1, 4'b0101, 4'b1010, 1, 5'b1_0000);
    step4("sk2", 1, 4'b0101, 4'b1010, 0, 5'b0_1111);

    step4("h0", 1, 4'b0011, 4'b0100, 1, 5'b0_1000);
    step4("h1", 0, 4'b1111, 4'b1111, 1, 5'b0_0000);
    step4("h2", 0, 4'b0001, 4'b1110, 0, 5'b0_0000);
    step4("h3", 0, 4'b1000, 4'b1000, 1, 5'b0_0000);
    for (int i = 0; i < LAT; i++) step4("h4", 0, 4'b0, 4'b0, 0, 5'b0);

    step4("m0", 1, 4'b1100, 4'b0111, 0, 5'b1_0011);
    for (int i = 1; i < LAT; i++) step4("m1", 0, 4'b0, 4'b0, 0, 5'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.v", 17'(b4.out_valid), 17'd0);
    chk("arst.s", 17'({b4.carry_out, b4.sum}), 17'd0);
    rst = 1'b0;
    restart();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          r = 5'(a) + 5'(b) + 5'(c);
          step4("ex", 1, 4'(a), 4'(b), 1'(c), r);
        end
      end
    end

    for (int i = 0; i < 10000; i++) begin
      step16("rnd", 16'($urandom), 16'($urandom), 1'($urandom));
    end
    step16("max", 16'hffff, 16'hffff, 1'b1);
    step16("skp", 16'hffff, 16'h0000, 1'b1);
    for (int i = 0; i < LAT; i++) step4("dr", 0, 4'b0, 4'b0, 0, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
